// File: rtl/class_score_packer_pkg.sv
// rtl/class_score_packer_pkg.sv - shared widths, state encoding and slot offset helper for the class score packer
package class_score_packer_pkg;

    localparam int DEFAULT_IN_WIDTH    = 16;
    localparam int DEFAULT_DATA_WIDTH  = 29;
    localparam int DEFAULT_NUM_CLASSES = 10;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        PRESENT = 2'd1,
        WAIT    = 2'd2
    } state_t;

    // Bit offset of class k inside the flat layer_out bus.
    function automatic int slot_offset(input int k, input int width);
        return k * width;
    endfunction

endpackage

// File: rtl/score_accumulator.sv
// rtl/score_accumulator.sv - signed score accumulator; SATURATE_EN selects clamping and a sticky saturation flag
module score_accumulator #(
    parameter int IN_WIDTH   = 16,
    parameter int DATA_WIDTH = 29
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         add,
    input  logic                         last,
    input  logic signed [IN_WIDTH-1:0]   add_data,
    output logic signed [DATA_WIDTH-1:0] sum
`ifdef SATURATE_EN
    ,
    output logic                         sat
`endif
);

    logic signed [DATA_WIDTH-1:0] acc;

`ifdef SATURATE_EN
    localparam logic signed [DATA_WIDTH-1:0] MAX_VAL = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [DATA_WIDTH-1:0] MIN_VAL = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    logic signed [DATA_WIDTH:0] wide;
    logic                       overflow;

    // One guard bit is enough: a single add can only overflow by one bit.
    always_comb begin
        wide     = {acc[DATA_WIDTH-1], acc} + (DATA_WIDTH+1)'(add_data);
        overflow = wide[DATA_WIDTH] != wide[DATA_WIDTH-1];
        sum      = overflow ? (wide[DATA_WIDTH] ? MIN_VAL : MAX_VAL) : wide[DATA_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat <= 1'b0;
        end else if (clear) begin
            sat <= 1'b0;
        end else if (add && overflow) begin
            sat <= 1'b1;
        end
    end
`else
    always_comb begin
        sum = acc + DATA_WIDTH'(add_data);
    end
`endif

    // The completed sum is consumed by the packer in the same cycle, so acc restarts at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (add) begin
            acc <= last ? '0 : sum;
        end
    end

endmodule

// File: rtl/class_score_packer.sv
// rtl/class_score_packer.sv - packs per-neuron score sums into layer_out and hands frames to the comparator; SATURATE_EN adds sat_flag
module class_score_packer
    import class_score_packer_pkg::*;
#(
    parameter int IN_WIDTH    = DEFAULT_IN_WIDTH,
    parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
    parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              s_valid,
    input  logic signed [IN_WIDTH-1:0]        s_data,
    input  logic                              s_last,
    output logic                              s_ready,
    output logic [DATA_WIDTH*NUM_CLASSES-1:0] layer_out,
    output logic                              valid,
    input  logic                              cmp_ready,
    output logic [15:0]                       frame_done_cnt
`ifdef SATURATE_EN
    ,
    output logic                              sat_flag
`endif
);

    localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

    state_t                       state, state_next;
    logic                         run;
    logic [IDX_W-1:0]             idx;
    logic signed [DATA_WIDTH-1:0] sum;
    logic                         accept, neuron_done, frame_ack;

    assign accept      = s_valid && s_ready;
    assign neuron_done = accept && s_last;
    assign frame_ack   = (state == WAIT) && cmp_ready;

    score_accumulator #(
        .IN_WIDTH  (IN_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_acc (
        .clk     (clk),
        .rst     (rst),
        .clear   (frame_ack),
        .add     (accept),
        .last    (s_last),
        .add_data(s_data),
        .sum     (sum)
`ifdef SATURATE_EN
        ,
        .sat     (sat_flag)
`endif
    );

    // run keeps s_ready low for the whole reset window and the release edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ACCUM:   if (neuron_done && idx == LAST_IDX) state_next = PRESENT;
            PRESENT: state_next = WAIT;
            WAIT:    if (cmp_ready) state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    always_comb begin
        s_ready = run && (state == ACCUM);
        valid   = (state == PRESENT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx            <= '0;
            layer_out      <= '0;
            frame_done_cnt <= '0;
        end else if (frame_ack) begin
            idx            <= '0;
            layer_out      <= '0;
            frame_done_cnt <= frame_done_cnt + 16'd1;
        end else if (neuron_done) begin
            layer_out[slot_offset(int'(idx), DATA_WIDTH) +: DATA_WIDTH] <= sum;
            idx <= idx + IDX_W'(1);
        end
    end

endmodule

// File: tb/tb_class_score_packer.sv
// tb/tb_class_score_packer.sv - scoreboard bench with randomized frames against a summed-score reference model
`timescale 1ns/1ps
module tb_class_score_packer;

    localparam int IW = 16;
    localparam int DW = 29;
    localparam int NC = 10;
    localparam int LW = DW * NC;
    localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
    localparam longint MINV = -(longint'(1) << (DW - 1));

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic [IW-1:0] s_data = '0;
    logic          s_last = 1'b0;
    logic          s_ready;
    logic [LW-1:0] layer_out;
    logic          valid;
    logic          cmp_ready = 1'b0;
    logic [15:0]   frame_done_cnt;
`ifdef SATURATE_EN
    logic          sat_flag;
`endif

    class_score_packer dut (
        .clk           (clk),
        .rst           (rst),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .layer_out     (layer_out),
        .valid         (valid),
        .cmp_ready     (cmp_ready),
        .frame_done_cnt(frame_done_cnt)
`ifdef SATURATE_EN
        ,
        .sat_flag      (sat_flag)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [LW-1:0] data;
        int            cnt;
        logic          sat;
        time           end_time;
    } exp_t;

    exp_t   exp_q[$];
    int     fr[NC][$];
    int     n_checks = 0;
    int     n_pass = 0;
    int     n_frames = 0;
    time    last_acc_time = 0;
    logic   spur_req = 1'b0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Reference: a slot is the plain sum of its beats, wrapped to DW bits or clamped per add.
    task automatic model_frame(output logic [LW-1:0] data, output logic sat);
        data = '0;
        sat  = 1'b0;
        for (int k = 0; k < NC; k++) begin
            longint s = 0;
            logic [63:0] bits;
            foreach (fr[k][b]) begin
                s = s + longint'(fr[k][b]);
`ifdef SATURATE_EN
                if (s > MAXV) begin s = MAXV; sat = 1'b1; end
                if (s < MINV) begin s = MINV; sat = 1'b1; end
`endif
            end
            bits = s;
            data[k*DW +: DW] = bits[DW-1:0];
        end
    endtask

    task automatic send_beat(input int d, input logic l);
        logic ok;
        int   n;
        ok = 1'b0;
        n  = 0;
        s_valid = 1'b1;
        s_data  = IW'(d);
        s_last  = l;
        while (!ok && n < 1000) begin
            @(negedge clk);
            ok = s_ready;
            @(posedge clk);
            if (ok) last_acc_time = $time;
            #1;
            n++;
        end
        if (!ok) check("beat_timeout", 1'b0, 1'b1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input int spur_after);
        exp_t e;
        model_frame(e.data, e.sat);
        e.cnt = n_frames;
        e.end_time = 0;
        exp_q.push_back(e);
        n_frames++;
        for (int k = 0; k < NC; k++) begin
            foreach (fr[k][b]) send_beat(fr[k][b], b == fr[k].size() - 1);
            if (k == spur_after) begin
                logic [LW-1:0] snap;
                logic [15:0]   cnt_snap;
                snap = layer_out;
                cnt_snap = frame_done_cnt;
                spur_req = 1'b1;
                for (int i = 0; i < 20 && spur_req; i++) @(posedge clk);
                #1;
                check("spur_cnt", LW'(frame_done_cnt), LW'(cnt_snap));
                check("spur_layer", layer_out, snap);
            end
        end
        exp_q[exp_q.size()-1].end_time = last_acc_time;
    endtask

    task automatic clear_frame();
        for (int k = 0; k < NC; k++) fr[k].delete();
    endtask

    // Comparator model: acknowledge two cycles after valid, or emit a stray pulse on request.
    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                cmp_ready = 1'b1;
                @(posedge clk); #1;
                cmp_ready = 1'b0;
            end else if (spur_req) begin
                @(posedge clk); #1;
                cmp_ready = 1'b1;
                @(posedge clk); #1;
                cmp_ready = 1'b0;
                spur_req = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("frame_data", layer_out, e.data);
                    check("frame_cnt", LW'(frame_done_cnt), LW'(e.cnt));
                    check("ready_low_in_present", LW'(s_ready), '0);
                    check("valid_latency", LW'($time - e.end_time), LW'(5));
`ifdef SATURATE_EN
                    check("sat_flag", LW'(sat_flag), LW'(e.sat));
`endif
                    @(negedge clk);
                    check("valid_one_cycle", LW'(valid), '0);
                    check("hold_in_wait", layer_out, e.data);
                end
            end
        end
    end

    initial begin
        #3;
        check("rst_s_ready", LW'(s_ready), '0);
        check("rst_valid", LW'(valid), '0);
        check("rst_layer", layer_out, '0);
        check("rst_cnt", LW'(frame_done_cnt), '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_after_release", LW'(s_ready), LW'(1));

        // Three neurons, then an asynchronous reset in the middle of ACCUM.
        for (int k = 0; k < 3; k++) begin
            send_beat(k, 1'b0);
            send_beat(1, 1'b1);
        end
        for (int k = 0; k < 3; k++) check("partial_slot", LW'(layer_out[k*DW +: DW]), LW'(k + 1));
        #1 rst = 1'b1;
        #1;
        check("midrst_layer", layer_out, '0);
        check("midrst_s_ready", LW'(s_ready), '0);
        check("midrst_valid", LW'(valid), '0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midrst_ready_back", LW'(s_ready), LW'(1));

        // Basic frame: slot k = k + 1.
        clear_frame();
        for (int k = 0; k < NC; k++) begin fr[k].push_back(k); fr[k].push_back(1); end
        send_frame(-1);

        // Negative sums; other slots single zero beats. First beat is held through PRESENT/WAIT.
        clear_frame();
        fr[0].push_back(100);
        for (int k = 1; k < NC; k++) fr[k].push_back(0);
        fr[3].delete();
        fr[3].push_back(-5);
        fr[3].push_back(-7);
        send_frame(-1);

        // Random frames, one with a stray comparator pulse mid-frame.
        for (int f = 0; f < 6; f++) begin
            clear_frame();
            for (int k = 0; k < NC; k++) begin
                int nb = int'($urandom_range(1, 4));
                for (int b = 0; b < nb; b++) fr[k].push_back(int'($urandom_range(0, 65535)) - 32768);
            end
            send_frame(f == 2 ? 4 : -1);
        end

        // Large positive run on slot 0 overflows DW-bit signed range.
        clear_frame();
        for (int b = 0; b < 16384; b++) fr[0].push_back(32767);
        for (int k = 1; k < NC; k++) fr[k].push_back(0);
        send_frame(-1);

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && int'(frame_done_cnt) == n_frames) break;
        end
        check("queue_drained", LW'(exp_q.size()), '0);
        check("final_cnt", LW'(frame_done_cnt), LW'(n_frames));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
